// File: rtl/outlier_dot_engine.sv
// outlier_dot_engine
// Streaming dot-product engine that splits each beat into narrow inlier
// products and wide outlier products. Outliers beyond the wide-lane count
// are serviced over extra passes, so every group result is exact.
// Beats accumulate until in_last; the group sum and the group's outlier
// count are then presented on a valid/ready output.

module outlier_dot_engine #(
  parameter int DIMM   = 64,
  parameter int DW     = 8,
  parameter int LW     = 4,
  parameter int NUM_LR = 4,
  parameter int ACC_W  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DIMM*DW-1:0]            in_a,
  input  logic [DIMM*DW-1:0]            in_w,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_W-1:0]              out_data,
  output logic [$clog2(DIMM)+16-1:0]    out_nout
);

  localparam int NW = $clog2(DIMM) + 16;  // group outlier count width
  localparam int NC = $clog2(DIMM + 1);   // per-beat outlier count width

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // An element is an outlier when it cannot be represented in LW signed bits,
  // i.e. the bits from the LW-1 sign position upward are not all equal.
  function automatic logic is_outlier(input logic [DW-1:0] v);
    logic [DW-LW:0] hi;
    hi = v[DW-1:LW-1];
    return !((&hi) || !(|hi));
  endfunction

  // Number of set bits in a lane mask.
  function automatic logic [NC-1:0] popcount(input logic [DIMM-1:0] m);
    logic [NC-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DIMM; i++) begin
      cnt = cnt + NC'(m[i]);
    end
    return cnt;
  endfunction

  // Registered state
  state_e             state_q, state_d;
  logic [DIMM*DW-1:0] a_q, a_d;
  logic [DIMM*DW-1:0] w_q, w_d;
  logic               last_q, last_d;
  logic [DIMM-1:0]    mask_q, mask_d;
  logic [NC-1:0]      nout_q, nout_d;
  logic               first_q, first_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [NW-1:0]      gcnt_q, gcnt_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_data_q, out_data_d;
  logic [NW-1:0]      out_nout_q, out_nout_d;

  // Combinational helpers
  logic [DIMM-1:0]    in_mask_s;
  logic [NC-1:0]      in_nout_s;
  logic [DIMM-1:0]    sel_s;
  logic [DIMM-1:0]    rem_s;
  logic [ACC_W-1:0]   inl_sum_s;
  logic [ACC_W-1:0]   lr_sum_s;
  logic [ACC_W-1:0]   contrib_s;
  logic [ACC_W-1:0]   acc_next_s;
  logic               final_s;
  logic [NW:0]        gsum_s;
  logic [NW-1:0]      gcnt_sat_s;
  logic               in_ready_s;
  logic               accept_s;

  assign in_ready_s = (state_q == ST_IDLE) && rst_n;
  assign accept_s   = in_valid && in_ready_s;

  // Classify the incoming beat's elements and count its outliers.
  always_comb begin
    in_mask_s = '0;
    for (int i = 0; i < DIMM; i++) begin
      in_mask_s[i] = is_outlier(in_a[i*DW +: DW]) || is_outlier(in_w[i*DW +: DW]);
    end
    in_nout_s = popcount(in_mask_s);
  end

  // One pass: inlier products (only counted on the first pass, while the mask
  // still marks every outlier) plus the lowest-indexed NUM_LR pending outliers.
  always_comb begin : pass_dp
    logic signed [DW-1:0]   a_el;
    logic signed [DW-1:0]   w_el;
    logic signed [LW-1:0]   a_nr;
    logic signed [LW-1:0]   w_nr;
    logic signed [2*DW-1:0] p_wide;
    logic signed [2*LW-1:0] p_narrow;
    int                     taken;
    sel_s     = '0;
    inl_sum_s = '0;
    lr_sum_s  = '0;
    taken     = 0;
    for (int i = 0; i < DIMM; i++) begin
      a_el     = a_q[i*DW +: DW];
      w_el     = w_q[i*DW +: DW];
      a_nr     = a_q[i*DW +: LW];
      w_nr     = w_q[i*DW +: LW];
      p_wide   = (2*DW)'(a_el) * (2*DW)'(w_el);
      p_narrow = (2*LW)'(a_nr) * (2*LW)'(w_nr);
      if (mask_q[i] && (taken < NUM_LR)) begin
        sel_s[i] = 1'b1;
        taken    = taken + 1;
        lr_sum_s = lr_sum_s + ACC_W'(p_wide);
      end else begin
        sel_s[i] = 1'b0;
      end
      if (!mask_q[i]) begin
        inl_sum_s = inl_sum_s + ACC_W'(p_narrow);
      end else begin
        inl_sum_s = inl_sum_s;
      end
    end
    rem_s   = mask_q & ~sel_s;
    final_s = (rem_s == '0);
    if (first_q) begin
      contrib_s = lr_sum_s + inl_sum_s;
    end else begin
      contrib_s = lr_sum_s;
    end
    acc_next_s = acc_q + contrib_s;
  end

  // Group outlier count plus this beat's count, saturating at all-ones.
  always_comb begin
    gsum_s = {1'b0, gcnt_q} + (NW+1)'(nout_q);
    if (gsum_s[NW]) begin
      gcnt_sat_s = '1;
    end else begin
      gcnt_sat_s = gsum_s[NW-1:0];
    end
  end

  // Next-state logic: accept in IDLE, run passes in BUSY, commit or hold.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    w_d         = w_q;
    last_d      = last_q;
    mask_d      = mask_q;
    nout_d      = nout_q;
    first_d     = first_q;
    acc_d       = acc_q;
    gcnt_d      = gcnt_q;
    out_data_d  = out_data_q;
    out_nout_d  = out_nout_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          a_d     = in_a;
          w_d     = in_w;
          last_d  = in_last;
          mask_d  = in_mask_s;
          nout_d  = in_nout_s;
          first_d = 1'b1;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (!final_s) begin
          acc_d   = acc_next_s;
          mask_d  = rem_s;
          first_d = 1'b0;
        end else if (!last_q) begin
          acc_d   = acc_next_s;
          gcnt_d  = gcnt_sat_s;
          mask_d  = '0;
          first_d = 1'b0;
          state_d = ST_IDLE;
        end else if (!out_valid_q || out_ready) begin
          // Output slot is free (or being freed this edge): commit the group.
          out_data_d  = acc_next_s;
          out_nout_d  = gcnt_sat_s;
          out_valid_d = 1'b1;
          acc_d       = '0;
          gcnt_d      = '0;
          mask_d      = '0;
          first_d     = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          // Previous result still pending: hold this pass unchanged.
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
        mask_d  = '0;
      end
    endcase
  end

  // State and output registers; reset discards any partial group or result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      w_q         <= '0;
      last_q      <= 1'b0;
      mask_q      <= '0;
      nout_q      <= '0;
      first_q     <= 1'b0;
      acc_q       <= '0;
      gcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_nout_q  <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      w_q         <= w_d;
      last_q      <= last_d;
      mask_q      <= mask_d;
      nout_q      <= nout_d;
      first_q     <= first_d;
      acc_q       <= acc_d;
      gcnt_q      <= gcnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_nout_q  <= out_nout_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_nout  = out_nout_q;

endmodule

// File: tb/tb_outlier_dot_engine.sv
// Directed testbench for outlier_dot_engine with hand-computed expectations.

module tb_outlier_dot_engine;

  localparam int DIMM  = 64;
  localparam int DW    = 8;
  localparam int ACC_W = 32;
  localparam int NW    = $clog2(DIMM) + 16;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [DIMM*DW-1:0] in_a;
  logic [DIMM*DW-1:0] in_w;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_data;
  logic [NW-1:0]      out_nout;

  int checks;
  int failures;

  outlier_dot_engine #(
    .DIMM(DIMM), .DW(DW), .LW(4), .NUM_LR(4), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_w(in_w), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_nout(out_nout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int av, input int wv);
    for (int i = 0; i < DIMM; i++) begin
      in_a[i*DW +: DW] = DW'(av);
      in_w[i*DW +: DW] = DW'(wv);
    end
  endtask

  task automatic set_el(input int i, input int av, input int wv);
    in_a[i*DW +: DW] = DW'(av);
    in_w[i*DW +: DW] = DW'(wv);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, which must be accepted at the next edge; returns in cycle t+1.
  task automatic send(input logic last);
    chk("send_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    fill(0, 0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    fill(0, 0);
    #2;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_data", {32'd0, out_data}, 64'd0);
    chk("rst_nout", {42'd0, out_nout}, 64'd0);
    cyc();
    cyc();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // All ones, single last beat: 64, no outliers, P=1
    fill(1, 1);
    send(1'b1);
    chk("t1_ready_t1", {63'd0, in_ready}, 64'd0);
    chk("t1_valid_t1", {63'd0, out_valid}, 64'd0);
    cyc();
    chk("t1_valid_t2", {63'd0, out_valid}, 64'd1);
    chk("t1_data", {32'd0, out_data}, 64'd64);
    chk("t1_nout", {42'd0, out_nout}, 64'd0);
    chk("t1_ready_t2", {63'd0, in_ready}, 64'd1);
    cyc();
    chk("t1_valid_drop", {63'd0, out_valid}, 64'd0);

    // Four outliers fit one pass: 4*100*2 = 800
    fill(0, 0);
    for (int i = 0; i < 4; i++) set_el(i, 100, 2);
    send(1'b1);
    chk("t2_ready_t1", {63'd0, in_ready}, 64'd0);
    cyc();
    chk("t2_ready_t2", {63'd0, in_ready}, 64'd1);
    chk("t2_valid", {63'd0, out_valid}, 64'd1);
    chk("t2_data", {32'd0, out_data}, 64'd800);
    chk("t2_nout", {42'd0, out_nout}, 64'd4);
    cyc();

    // Nine outliers -> 3 passes: 9*16129 + 55 = 145216
    fill(1, 1);
    for (int i = 0; i < 9; i++) set_el(i, 127, 127);
    send(1'b1);
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("t3_ready_t%0d", k), {63'd0, in_ready}, 64'd0);
      chk($sformatf("t3_valid_t%0d", k), {63'd0, out_valid}, 64'd0);
      if (k < 3) cyc();
    end
    cyc();
    chk("t3_valid_t4", {63'd0, out_valid}, 64'd1);
    chk("t3_ready_t4", {63'd0, in_ready}, 64'd1);
    chk("t3_data", {32'd0, out_data}, 64'd145216);
    chk("t3_nout", {42'd0, out_nout}, 64'd9);
    cyc();

    // Three-beat group of -1*1: single result -192
    fill(-1, 1);
    send(1'b0);
    cyc();
    chk("t4_no_valid_b1", {63'd0, out_valid}, 64'd0);
    fill(-1, 1);
    send(1'b0);
    cyc();
    chk("t4_no_valid_b2", {63'd0, out_valid}, 64'd0);
    fill(-1, 1);
    send(1'b1);
    cyc();
    chk("t4_valid", {63'd0, out_valid}, 64'd1);
    chk("t4_data", {32'd0, out_data}, 64'h0000_0000_FFFF_FF40);
    chk("t4_nout", {42'd0, out_nout}, 64'd0);
    cyc();

    // Output hold: result 64 pending while a second group (800) completes
    out_ready = 1'b0;
    fill(1, 1);
    send(1'b1);
    cyc();
    chk("t5_g1_valid", {63'd0, out_valid}, 64'd1);
    chk("t5_g1_data", {32'd0, out_data}, 64'd64);
    for (int i = 0; i < 4; i++) set_el(i, 100, 2);
    send(1'b1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t5_hold_ready_%0d", k), {63'd0, in_ready}, 64'd0);
      chk($sformatf("t5_hold_data_%0d", k), {32'd0, out_data}, 64'd64);
      chk($sformatf("t5_hold_valid_%0d", k), {63'd0, out_valid}, 64'd1);
      cyc();
    end
    out_ready = 1'b1;
    chk("t5_deliver_64", {32'd0, out_data}, 64'd64);
    cyc();
    chk("t5_g2_valid", {63'd0, out_valid}, 64'd1);
    chk("t5_g2_data", {32'd0, out_data}, 64'd800);
    chk("t5_g2_nout", {42'd0, out_nout}, 64'd4);
    chk("t5_ready_after", {63'd0, in_ready}, 64'd1);
    cyc();
    chk("t5_valid_drop", {63'd0, out_valid}, 64'd0);

    // Reset during BUSY of a group's second beat discards the partial sum
    fill(1, 1);
    send(1'b0);
    cyc();
    fill(1, 1);
    for (int i = 0; i < 9; i++) set_el(i, 127, 127);
    send(1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("t6_rst_data", {32'd0, out_data}, 64'd0);
    chk("t6_rst_nout", {42'd0, out_nout}, 64'd0);
    chk("t6_rst_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    fill(1, 1);
    send(1'b1);
    cyc();
    chk("t6_valid", {63'd0, out_valid}, 64'd1);
    chk("t6_data", {32'd0, out_data}, 64'd64);
    chk("t6_nout", {42'd0, out_nout}, 64'd0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/outlier_dot_engine.md
# outlier_dot_engine

- Streaming outlier-aware dot-product engine; next generation of the fixed 64-lane inlier/outlier datapath.
- Each accepted beat carries DIMM activation/weight pairs. Elements fitting LW-bit signed go to narrow inlier multipliers; the rest are outliers served by NUM_LR wide lanes.
- When outliers exceed NUM_LR, the beat takes extra passes instead of losing precision, so results are always exact.
- Beats accumulate across a group (closed by `in_last`); the group sum is emitted on a valid/ready output to the downstream requantiser.

## Interface
- DIMM, 64, elements per beat (≥2)
- DW, 8, signed operand width
- LW, 4, inlier signed width (LW < DW)
- NUM_LR, 4, outlier lanes per pass (1..DIMM)
- ACC_W, 32, accumulator/result width (≥ 2*DW+$clog2(DIMM))
- Reset: `rst_n`, asynchronous, active-low. Clock: `clk`.
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid&&in_ready
- in_a  in  DIMM×DW  activations, signed
- in_w  in  DIMM×DW  weights, signed
- in_last  in  1  final beat of group
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid&&out_ready
- out_data  out  ACC_W  signed group dot product
- out_nout  out  $clog2(DIMM)+16  total outlier elements in group (saturating)

## Operation
- Element i is an outlier if in_a[i] or in_w[i] lies outside [-2^(LW-1), 2^(LW-1)-1].
- On acceptance, register a, w, last and the outlier mask; nout = popcount(mask).
- Pass count P = max(1, ceil(nout/NUM_LR)).
- FSM IDLE → BUSY on acceptance. BUSY runs P pass cycles, then → IDLE.
- Pass 1 adds the sum of all inlier products (LW×LW, sign-extended) to the accumulator.
- Every pass services the lowest-indexed ≤NUM_LR remaining mask bits, adds their DW×DW products, and clears those bits.
- The final pass ends when the remaining mask is zero after servicing.
- Final pass of a last beat:
  - out_data ← acc + contribution; out_nout ← group count + nout; out_valid ← 1.
  - Accumulator and group count clear.
- Final pass of a non-last beat: accumulator keeps acc + contribution.
- Output hold: if out_valid && !out_ready when a last-beat final pass would commit, the FSM stays on that pass with no state change until out_ready.
  - out_ready high in that cycle frees the slot: old result leaves, new one loads in the same edge.
- out_valid drops on out_ready when no new result commits that edge.
- Arithmetic: all sums are two's complement, wrap modulo 2^ACC_W. out_nout saturates at all-ones.
- in_ready = (state==IDLE) && rst_n.
- Reset (any time, including mid-BUSY or with a result pending):
  - state IDLE; acc, group count, mask cleared.
  - out_valid=0, out_data=0, out_nout=0.
  - Partial group and pending result discarded.

## Timing
- Beat accepted at edge t: BUSY during cycles t+1..t+P; in_ready=0 for those cycles, 1 at t+P+1 unless held.
- Last beat: out_valid first visible in cycle t+P+1 (P=1 → 2 cycles after acceptance), plus any hold cycles.
- Throughput: one beat per P+1 cycles.
- out_data/out_nout are stable while out_valid && !out_ready.
- in_a/in_w need not be held after acceptance.

## Test plan
- All a=1, w=1, DIMM=64, single last beat → out_data=64, out_nout=0, P=1, out_valid in cycle t+2.
- a[0..3]=100, w[0..3]=2, rest 0 → out_data=800, out_nout=4, P=1, in_ready low only in cycle t+1.
- a[0..8]=w[0..8]=127, rest a=w=1 → out_data=145216, out_nout=9, P=3, in_ready low t+1..t+3, out_valid at t+4.
- Three beats a=-1, w=1 (inlier), in_last on third → single result out_data=-192; no out_valid after beats 1–2.
- out_ready=0, group1 (=64) pending, group2 last beat (=800) arrives → FSM holds, in_ready stays 0.
  - Raise out_ready → 64 then 800 delivered in order; none lost or duplicated.
- Assert rst_n low during BUSY of a group's second beat → all outputs 0 immediately.
  - Next group of one beat (=64) → out_data=64, unaffected by the discarded partial.
